demux_scheduler: RTL and testbench

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_sched_pkg.sv | 12 +
 rtl/demux_scheduler_rr_next_lane.sv | 23 ++
 rtl/demux_scheduler.sv | 104 ++++++++++
 tb/tb_demux_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared lane constants and controller state for the demux scheduler
package demux_sched_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_scheduler_rr_next_lane.sv
// rtl/demux_scheduler_rr_next_lane.sv - first enabled lane at or after a start index, cyclic
module rr_next_lane
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0]     start,
  input  logic [NUM_LANES-1:0] mask,
  output logic [SEL_W-1:0]     lane,
  output logic                 found
);

  // Scan from the farthest offset down so the nearest enabled lane wins.
  always_comb begin
    lane  = start;
    found = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[start + SEL_W'(i)]) begin
        lane  = start + SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_scheduler.sv
// rtl/demux_scheduler.sv - one-word holding stage that deals bursts of words round-robin to four lanes
module demux_scheduler
  import demux_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_LANES-1:0] lane_en,
  output logic [WIDTH-1:0]     dout,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 busy
);

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold_data;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] cur;
  logic [3:0]       cnt;

  logic             hold_valid;
  logic             transfer;
  logic             accept;
  logic [SEL_W-1:0] tgt;
  logic             tgt_found;
  logic [SEL_W-1:0] adv;
  logic             adv_found;
  logic [3:0]       base_cnt;
  logic             last_word;

  assign hold_valid = (state == FULL);
  assign transfer   = hold_valid & out_ready[sel_q];
  assign in_ready   = ~rst & tgt_found & (~hold_valid | transfer);
  assign accept     = in_valid & in_ready;

  rr_next_lane u_target (
    .start (cur),
    .mask  (lane_en),
    .lane  (tgt),
    .found (tgt_found)
  );

  rr_next_lane u_advance (
    .start (tgt + SEL_W'(1)),
    .mask  (lane_en),
    .lane  (adv),
    .found (adv_found)
  );

  // Skipping past a disabled pointer starts a fresh burst on the new lane.
  assign base_cnt  = (tgt == cur) ? cnt : 4'd0;
  assign last_word = (base_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (transfer && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      sel_q     <= '0;
      cur       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      hold_data <= din;
      sel_q     <= tgt;
      if (last_word) begin
        cnt <= 4'd0;
        cur <= adv_found ? adv : tgt;
      end else begin
        cnt <= base_cnt + 4'd1;
        cur <= tgt;
      end
    end
  end

  assign dout      = hold_data;
  assign sel       = sel_q;
  assign busy      = hold_valid;
  assign out_valid = hold_valid ? (NUM_LANES'(1) << sel_q) : '0;

endmodule

// File: tb/tb_demux_scheduler.sv
// tb/tb_demux_scheduler.sv - scoreboard bench for demux_scheduler with BURST=4 and BURST=1 instances
module tb_demux_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;
  logic [3:0] lane_en = 4'hF;
  logic [3:0] out_ready = 4'hF;

  logic       ir   [2];
  logic [7:0] dout [2];
  logic [1:0] sel  [2];
  logic [3:0] ov   [2];
  logic       busy [2];

  always #5 clk = ~clk;

  demux_scheduler #(.WIDTH(8), .BURST(4)) dut0 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(ir[0]),
    .lane_en(lane_en), .dout(dout[0]), .sel(sel[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .busy(busy[0])
  );

  demux_scheduler #(.WIDTH(8), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(ir[1]),
    .lane_en(lane_en), .dout(dout[1]), .sel(sel[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .busy(busy[1])
  );

  int checks = 0;
  int failures = 0;

  function void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, k, act, exp);
    end
  endfunction

  // Reference model: words counted per burst, lanes picked by cyclic scan.
  int         burst_of [2] = '{4, 1};
  int         m_cur [2];
  int         m_cnt [2];
  logic [9:0] q [2][$];
  logic       pend_v [2];
  logic [9:0] pend [2];
  int         dlane [2][256];

  function automatic logic [9:0] model_accept(int k, logic [3:0] en, logic [7:0] d);
    int t = -1;
    int n = -1;
    for (int s = 0; s < 4; s++)
      if (t < 0 && en[(m_cur[k] + s) % 4]) t = (m_cur[k] + s) % 4;
    if (t != m_cur[k]) m_cnt[k] = 0;
    m_cnt[k]++;
    if (m_cnt[k] == burst_of[k]) begin
      m_cnt[k] = 0;
      for (int s = 1; s <= 4; s++)
        if (n < 0 && en[(t + s) % 4]) n = (t + s) % 4;
      m_cur[k] = n;
    end else begin
      m_cur[k] = t;
    end
    return {t[1:0], d};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pend_v[k] = 1'b0;
      if (!rst && in_valid && ir[k]) begin
        pend[k]   = model_accept(k, lane_en, din);
        pend_v[k] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (pend_v[k]) begin
        q[k].push_back(pend[k]);
        pend_v[k] = 1'b0;
      end
  end

  always @(negedge clk) begin : monitor
    logic [9:0] f;
    logic       exp_ir;
    for (int k = 0; k < 2; k++) begin
      if (q[k].size() != 0) f = q[k][0];
      else f = 10'h0;
      exp_ir = !rst && (lane_en != 4'h0) && (q[k].size() == 0 || out_ready[f[9:8]]);
      chk("in_ready", k, 32'(ir[k]), 32'(exp_ir));
      chk("busy", k, 32'(busy[k]), 32'(q[k].size() != 0));
      if (q[k].size() != 0) begin
        chk("out_valid", k, 32'(ov[k]), 32'd1 << f[9:8]);
        chk("sel", k, 32'(sel[k]), 32'(f[9:8]));
        chk("dout", k, 32'(dout[k]), 32'(f[7:0]));
        if (out_ready[f[9:8]]) begin
          dlane[k][f[7:0]] = int'(sel[k]);
          void'(q[k].pop_front());
        end
      end else begin
        chk("out_valid_idle", k, 32'(ov[k]), 32'h0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] rdy, input logic [3:0] en);
    @(posedge clk);
    #1;
    in_valid  = v;
    din       = d;
    out_ready = rdy;
    lane_en   = en;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 32'h0);
      chk("rst_busy", k, 32'(busy[k]), 32'h0);
      chk("rst_in_ready", k, 32'(ir[k]), 32'h0);
      chk("rst_sel", k, 32'(sel[k]), 32'h0);
      chk("rst_dout", k, 32'(dout[k]), 32'h0);
      q[k].delete();
      pend_v[k] = 1'b0;
      m_cur[k]  = 0;
      m_cnt[k]  = 0;
      for (int j = 0; j < 256; j++) dlane[k][j] = 99;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // 16 back-to-back words, all lanes enabled and ready
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 4'hF, 4'hF);
    repeat (3) cyc(1'b0, 8'h00, 4'hF, 4'hF);
    for (int i = 0; i < 16; i++) chk("burst4_lane", 0, 32'(dlane[0][i]), 32'(i / 4));

    // BURST=1 over lanes 1 and 3 only
    do_reset();
    cyc(1'b1, 8'h0A, 4'hF, 4'b1010);
    cyc(1'b1, 8'h0B, 4'hF, 4'b1010);
    cyc(1'b1, 8'h0C, 4'hF, 4'b1010);
    repeat (3) cyc(1'b0, 8'h00, 4'hF, 4'b1010);
    chk("rr_lane_a", 1, 32'(dlane[1][8'h0A]), 32'd1);
    chk("rr_lane_b", 1, 32'(dlane[1][8'h0B]), 32'd3);
    chk("rr_lane_c", 1, 32'(dlane[1][8'h0C]), 32'd1);

    // Stall lane 0 for five cycles, then release
    do_reset();
    cyc(1'b1, 8'h55, 4'h0, 4'hF);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h66, 4'h0, 4'hF);
    cyc(1'b1, 8'h66, 4'b0001, 4'hF);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("release_in_ready", k, 32'(ir[k]), 32'd1);
      chk("release_dout", k, 32'(dout[k]), 32'h55);
    end
    repeat (3) cyc(1'b0, 8'h00, 4'hF, 4'hF);

    // Lane enables cleared while a word is held
    do_reset();
    cyc(1'b1, 8'h77, 4'h0, 4'hF);
    cyc(1'b0, 8'h00, 4'h0, 4'h0);
    cyc(1'b1, 8'h78, 4'h0, 4'h0);
    cyc(1'b1, 8'h78, 4'hF, 4'h0);
    cyc(1'b1, 8'h78, 4'hF, 4'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("drain_busy", k, 32'(busy[k]), 32'd0);
      chk("drain_in_ready", k, 32'(ir[k]), 32'd0);
      chk("drain_lane", k, 32'(dlane[k][8'h77]), 32'd0);
    end

    // Reset mid-burst, then first word after release goes to lane 0
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h20 + 8'(i), 4'hF, 4'hF);
    do_reset();
    cyc(1'b1, 8'hE1, 4'hF, 4'hF);
    repeat (3) cyc(1'b0, 8'h00, 4'hF, 4'hF);
    for (int k = 0; k < 2; k++) chk("post_reset_lane", k, 32'(dlane[k][8'hE1]), 32'd0);

    // Randomised traffic, enables and back-pressure
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
          ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
    repeat (4) cyc(1'b0, 8'h00, 4'hF, 4'hF);
    for (int k = 0; k < 2; k++) chk("final_empty", k, 32'(q[k].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
